// File: rtl/alu_req_driver_if.sv
// ALU opcode subset and the request/ALU/response bundle
// shared between alu_req_driver and its environment.
package alu_req_driver_pkg;
    typedef enum logic [6:0] {
        ALU_LTS  = 7'b0000000,
        ALU_LTU  = 7'b0000001,
        ALU_SLTS = 7'b0000010,
        ALU_SLTU = 7'b0000011,
        ALU_ADD  = 7'b0011000,
        ALU_SUB  = 7'b0011001,
        ALU_DIVU = 7'b0110000,
        ALU_DIV  = 7'b0110001,
        ALU_REMU = 7'b0110010,
        ALU_REM  = 7'b0110011
    } alu_opcode_e;
endpackage

interface alu_req_driver_if;
    import alu_req_driver_pkg::*;

    logic        req_valid_i;
    logic        req_ready_o;
    alu_opcode_e req_op_i;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic [31:0] req_c_i;
    logic [1:0]  req_vmode_i;
    logic [3:0]  req_tag_i;

    logic        alu_enable_o;
    alu_opcode_e alu_operator_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [31:0] alu_c_o;
    logic [1:0]  alu_vmode_o;
    logic [4:0]  alu_bmask_a_o;
    logic [4:0]  alu_bmask_b_o;
    logic [1:0]  alu_imm_vec_ext_o;
    logic        alu_is_clpx_o;
    logic        alu_is_subrot_o;
    logic [1:0]  alu_clpx_shift_o;
    logic        alu_ready_i;
    logic [31:0] alu_result_i;
    logic        alu_cmp_i;
    logic        alu_ex_ready_o;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic        rsp_cmp_o;
    logic [3:0]  rsp_tag_o;
    logic        rsp_timeout_o;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, req_c_i,
        input  req_vmode_i, req_tag_i,
        output req_ready_o,
        output alu_enable_o, alu_operator_o, alu_a_o, alu_b_o, alu_c_o,
        output alu_vmode_o, alu_bmask_a_o, alu_bmask_b_o,
        output alu_imm_vec_ext_o, alu_is_clpx_o, alu_is_subrot_o,
        output alu_clpx_shift_o, alu_ex_ready_o,
        input  alu_ready_i, alu_result_i, alu_cmp_i,
        output rsp_valid_o, rsp_result_o, rsp_cmp_o, rsp_tag_o,
        output rsp_timeout_o,
        input  rsp_ready_i
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, req_c_i,
        output req_vmode_i, req_tag_i,
        input  req_ready_o,
        input  alu_enable_o, alu_operator_o, alu_a_o, alu_b_o, alu_c_o,
        input  alu_vmode_o, alu_bmask_a_o, alu_bmask_b_o,
        input  alu_imm_vec_ext_o, alu_is_clpx_o, alu_is_subrot_o,
        input  alu_clpx_shift_o, alu_ex_ready_o,
        output alu_ready_i, alu_result_i, alu_cmp_i,
        input  rsp_valid_o, rsp_result_o, rsp_cmp_o, rsp_tag_o,
        input  rsp_timeout_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/alu_req_driver.sv
// Buffers ALU requests, drives one cv32e40p_alu and returns
// tagged results; aborts an operation that never becomes ready.
module alu_req_driver
    import alu_req_driver_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_req_driver_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;
    localparam logic [PW:0]   FULL_C = (PW+1)'(DEPTH);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT - 1);

    typedef struct packed {
        alu_opcode_e op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [1:0]  vmode;
        logic [3:0]  tag;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_RESP
    } state_e;

    req_t          mem_q [DEPTH];
    req_t          mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    state_e        state_q, state_d;
    req_t          iss_q, iss_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   res_q, res_d;
    logic          cmp_q, cmp_d;
    logic          tmo_q, tmo_d;
    logic [3:0]    tag_q, tag_d;

    logic full, empty, push, pop;
    logic enable, ex_ready;
    req_t req_in;

    assign full  = (count_q == FULL_C);
    assign empty = (count_q == '0);
    assign push  = bus.req_valid_i && !full;

    assign req_in = '{
        op:    bus.req_op_i,
        a:     bus.req_a_i,
        b:     bus.req_b_i,
        c:     bus.req_c_i,
        vmode: bus.req_vmode_i,
        tag:   bus.req_tag_i
    };

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = req_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        iss_d    = iss_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        cmp_d    = cmp_q;
        tmo_d    = tmo_q;
        tag_d    = tag_q;
        pop      = 1'b0;
        enable   = 1'b0;
        ex_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                enable = 1'b1;
                cnt_d  = (state_q == S_ISSUE) ? '0 : cnt_q + 1'b1;
                // ready beats the limit when both land together
                if (bus.alu_ready_i) begin
                    ex_ready = 1'b1;
                    res_d    = bus.alu_result_i;
                    cmp_d    = bus.alu_cmp_i;
                    tmo_d    = 1'b0;
                    tag_d    = iss_q.tag;
                    state_d  = S_RESP;
                end else if (state_q == S_WAIT && cnt_d == TO_LIM) begin
                    res_d   = '0;
                    cmp_d   = 1'b0;
                    tmo_d   = 1'b1;
                    tag_d   = iss_q.tag;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            iss_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            iss_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            cmp_q    <= 1'b0;
            tmo_q    <= 1'b0;
            tag_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            iss_q    <= iss_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            cmp_q    <= cmp_d;
            tmo_q    <= tmo_d;
            tag_q    <= tag_d;
        end
    end

    assign bus.req_ready_o       = !full;
    assign bus.alu_enable_o      = enable;
    assign bus.alu_ex_ready_o    = ex_ready;
    assign bus.alu_operator_o    = iss_q.op;
    assign bus.alu_a_o           = iss_q.a;
    assign bus.alu_b_o           = iss_q.b;
    assign bus.alu_c_o           = iss_q.c;
    assign bus.alu_vmode_o       = iss_q.vmode;
    assign bus.alu_bmask_a_o     = '0;
    assign bus.alu_bmask_b_o     = '0;
    assign bus.alu_imm_vec_ext_o = '0;
    assign bus.alu_is_clpx_o     = 1'b0;
    assign bus.alu_is_subrot_o   = 1'b0;
    assign bus.alu_clpx_shift_o  = '0;
    assign bus.rsp_valid_o       = (state_q == S_RESP);
    assign bus.rsp_result_o      = res_q;
    assign bus.rsp_cmp_o         = cmp_q;
    assign bus.rsp_tag_o         = tag_q;
    assign bus.rsp_timeout_o     = tmo_q;
endmodule

// File: tb/tb_alu_req_driver.sv
// Scoreboard bench for alu_req_driver with a behavioural
// ALU whose latency is set per test.
module tb_alu_req_driver;
    import alu_req_driver_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_req_driver_if bus ();

    alu_req_driver #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        cmp;
        logic [3:0]  tag;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int alu_lat = 0;
    int busy    = 0;
    bit rand_rdy = 1'b0;
    bit rdy_hold = 1'b1;

    always @(posedge clk) begin
        if (bus.alu_enable_o && !bus.alu_ex_ready_o) busy <= busy + 1;
        else busy <= 0;
    end

    always_comb begin
        bus.alu_ready_i  = (busy >= alu_lat);
        bus.alu_result_i = '0;
        bus.alu_cmp_i    = 1'b0;
        case (bus.alu_operator_o)
            ALU_ADD: bus.alu_result_i = bus.alu_a_o + bus.alu_b_o;
            ALU_SUB: bus.alu_result_i = bus.alu_a_o - bus.alu_b_o;
            ALU_SLTS: begin
                bus.alu_cmp_i    = $signed(bus.alu_a_o) < $signed(bus.alu_b_o);
                bus.alu_result_i = {31'b0, bus.alu_cmp_i};
            end
            ALU_SLTU: begin
                bus.alu_cmp_i    = bus.alu_a_o < bus.alu_b_o;
                bus.alu_result_i = {31'b0, bus.alu_cmp_i};
            end
            ALU_DIV: begin
                if (bus.alu_b_o == 0) bus.alu_result_i = '1;
                else bus.alu_result_i = 32'($signed(bus.alu_a_o) / $signed(bus.alu_b_o));
            end
            default: bus.alu_result_i = '0;
        endcase
    end

    initial begin
        bus.rsp_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.rsp_ready_i = 1'($urandom_range(0, 1));
            else bus.rsp_ready_i = rdy_hold;
        end
    end

    // Monitor: pops the scoreboard on each handshake and
    // checks that a stalled response does not move.
    bit          held = 1'b0;
    logic [31:0] h_res;
    logic        h_cmp, h_to;
    logic [3:0]  h_tag;
    exp_t        e;

    always @(negedge clk) begin
        if (held) begin
            checks++;
            if (!bus.rsp_valid_o || bus.rsp_result_o !== h_res || bus.rsp_cmp_o !== h_cmp
                || bus.rsp_tag_o !== h_tag || bus.rsp_timeout_o !== h_to) begin
                errors++;
                $display("FAIL rsp_hold: got v=%0b res=%0h tag=%0h want v=1 res=%0h tag=%0h",
                         bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_tag_o, h_res, h_tag);
            end
        end
        if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got tag=%0h res=%0h want no response",
                         bus.rsp_tag_o, bus.rsp_result_o);
            end else begin
                e = sb.pop_front();
                if (bus.rsp_result_o !== e.res || bus.rsp_cmp_o !== e.cmp
                    || bus.rsp_tag_o !== e.tag || bus.rsp_timeout_o !== e.to) begin
                    errors++;
                    $display("FAIL rsp_data: got res=%0h cmp=%0b tag=%0h to=%0b want res=%0h cmp=%0b tag=%0h to=%0b",
                             bus.rsp_result_o, bus.rsp_cmp_o, bus.rsp_tag_o, bus.rsp_timeout_o,
                             e.res, e.cmp, e.tag, e.to);
                end
            end
        end
        held = bus.rsp_valid_o && !bus.rsp_ready_i;
        h_res = bus.rsp_result_o;
        h_cmp = bus.rsp_cmp_o;
        h_tag = bus.rsp_tag_o;
        h_to  = bus.rsp_timeout_o;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input alu_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] er, input logic ec,
                        input logic eto, input bit track);
        bit   ok = 1'b0;
        logic r;
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_a_i     = a;
        bus.req_b_i     = b;
        bus.req_c_i     = a ^ b;
        bus.req_vmode_i = tag[1:0];
        bus.req_tag_i   = tag;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            r = bus.req_ready_o;
            cyc();
            if (r) ok = 1'b1;
        end
        bus.req_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_accept: got no accept want accept tag=%0h", tag);
        end else if (track) begin
            sb.push_back('{res: er, cmp: ec, tag: tag, to: eto});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
        cyc();
        check("drain_left", 32'(sb.size()), 32'd0);
        cyc();
    endtask

    task automatic wait_enable(input string nm);
        int n = 0;
        while (!bus.alu_enable_o && n < 20) begin
            cyc();
            n++;
        end
        check(nm, 32'(bus.alu_enable_o), 32'd1);
    endtask

    alu_opcode_e cmp_op [8] = '{ALU_SLTS, ALU_SLTU, ALU_SLTS, ALU_SLTU,
                                ALU_SLTS, ALU_SLTU, ALU_SLTS, ALU_SLTU};
    logic [31:0] cmp_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd3,
                                32'h8000_0000, 32'h8000_0000, 32'd7, 32'd0};
    logic [31:0] cmp_b  [8] = '{32'd1, 32'd1, 32'd3, 32'd5,
                                32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd7, 32'd1};
    logic        cmp_e  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        alu_opcode_e r_op;
        logic [31:0] r_a, r_b, r_c;
        int en_cyc, pulses, changes, seen;

        bus.req_valid_i = 1'b0;
        bus.req_op_i    = ALU_ADD;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        bus.req_c_i     = '0;
        bus.req_vmode_i = '0;
        bus.req_tag_i   = '0;

        rst_n = 1'b0;
        repeat (3) cyc();
        check("rst_enable", 32'(bus.alu_enable_o), 32'd0);
        check("rst_ex_ready", 32'(bus.alu_ex_ready_o), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_operator", 32'(bus.alu_operator_o), 32'd0);
        check("rst_alu_a", bus.alu_a_o, 32'd0);
        check("rst_rsp_result", bus.rsp_result_o, 32'd0);
        rst_n = 1'b1;
        cyc();
        check("rst_req_ready", 32'(bus.req_ready_o), 32'd1);

        // single-cycle ADD latency
        alu_lat = 0;
        push(ALU_ADD, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, 1'b0, 1'b1);
        check("add_idle_enable", 32'(bus.alu_enable_o), 32'd0);
        cyc();
        check("add_issue_enable", 32'(bus.alu_enable_o), 32'd1);
        check("add_issue_ex_ready", 32'(bus.alu_ex_ready_o), 32'd1);
        check("add_issue_a", bus.alu_a_o, 32'd5);
        check("add_issue_b", bus.alu_b_o, 32'd7);
        check("add_issue_c", bus.alu_c_o, 32'd2);
        check("add_issue_vmode", 32'(bus.alu_vmode_o), 32'd3);
        cyc();
        check("add_resp_enable", 32'(bus.alu_enable_o), 32'd0);
        check("add_resp_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("add_resp_result", bus.rsp_result_o, 32'd12);
        check("add_resp_tag", 32'(bus.rsp_tag_o), 32'd3);
        drain();

        // multi-cycle DIV held for 34 not-ready cycles
        alu_lat = 34;
        push(ALU_DIV, 32'd100, 32'd7, 4'd5, 32'd14, 1'b0, 1'b0, 1'b1);
        wait_enable("div_enable_seen");
        r_op = bus.alu_operator_o;
        r_a = bus.alu_a_o;
        r_b = bus.alu_b_o;
        r_c = bus.alu_c_o;
        en_cyc = 0;
        pulses = 0;
        changes = 0;
        while (bus.alu_enable_o && en_cyc < 200) begin
            en_cyc++;
            if (bus.alu_ex_ready_o) pulses++;
            if (bus.alu_operator_o != r_op || bus.alu_a_o != r_a
                || bus.alu_b_o != r_b || bus.alu_c_o != r_c) changes++;
            cyc();
        end
        check("div_operator", 32'(r_op), 32'(ALU_DIV));
        check("div_field_changes", 32'(changes), 32'd0);
        check("div_ex_ready_pulses", 32'(pulses), 32'd1);
        check("div_enable_cycles", 32'(en_cyc), 32'd35);
        check("div_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        drain();

        // fill FIFO behind a stalled response
        alu_lat = 0;
        rdy_hold = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            push(ALU_ADD, 32'(i * 10), 32'(i), 4'(i), 32'(i * 11), 1'b0, 1'b0, 1'b1);
        end
        check("fifo_full_ready", 32'(bus.req_ready_o), 32'd0);
        check("fifo_head_tag", 32'(bus.rsp_tag_o), 32'd0);
        repeat (3) cyc();
        check("fifo_still_full", 32'(bus.req_ready_o), 32'd0);
        rdy_hold = 1'b1;
        drain();

        // timeout abort, then normal op
        alu_lat = 1000;
        push(ALU_ADD, 32'd9, 32'd9, 4'd6, 32'd0, 1'b0, 1'b1, 1'b1);
        wait_enable("to_enable_seen");
        en_cyc = 0;
        while (bus.alu_enable_o && en_cyc < 200) begin
            en_cyc++;
            cyc();
        end
        check("to_enable_cycles", 32'(en_cyc), 32'(TIMEOUT));
        check("to_rsp_flag", 32'(bus.rsp_timeout_o), 32'd1);
        drain();
        alu_lat = 0;
        push(ALU_SUB, 32'd50, 32'd8, 4'd7, 32'd42, 1'b0, 1'b0, 1'b1);
        drain();

        // reset during WAIT drops the op and the queued one
        alu_lat = 1000;
        push(ALU_ADD, 32'd1, 32'd1, 4'd8, 32'd0, 1'b0, 1'b0, 1'b0);
        push(ALU_ADD, 32'd2, 32'd2, 4'd9, 32'd0, 1'b0, 1'b0, 1'b0);
        wait_enable("rstw_enable_seen");
        repeat (3) cyc();
        rst_n = 1'b0;
        cyc();
        check("rstw_enable", 32'(bus.alu_enable_o), 32'd0);
        check("rstw_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rstw_alu_a", bus.alu_a_o, 32'd0);
        check("rstw_tag", 32'(bus.rsp_tag_o), 32'd0);
        rst_n = 1'b1;
        alu_lat = 0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bus.alu_enable_o || bus.rsp_valid_o) seen++;
        end
        check("rstw_no_activity", 32'(seen), 32'd0);
        check("rstw_req_ready", 32'(bus.req_ready_o), 32'd1);

        // back-to-back compares with random response backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(cmp_op[i], cmp_a[i], cmp_b[i], 4'(i + 2),
                 {31'b0, cmp_e[i]}, cmp_e[i], 1'b0, 1'b1);
        end
        drain();
        rand_rdy = 1'b0;
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_req_driver.md
# alu_req_driver

Issue-side counterpart of the CV32E40P ALU port bundle. It accepts ALU operation requests over a valid/ready stream, buffers them, and drives `enable_i`, `operator_i` and the operand ports of one `cv32e40p_alu` instance. It holds those ports stable through multi-cycle operations (DIV/REM) while `ready_o` is low. It closes each operation with `ex_ready_i` and returns the tagged result on a response stream. It sits between the EX-stage sequencer or testbench stimulus core and the ALU.

## Interface
Parameters:
- DEPTH, 4, request FIFO entries; power of two, ≥2
- TIMEOUT, 64, max cycles in WAIT before abort; ≥2

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid & ready
- req_op_i  in  alu_opcode_e  ALU operator
- req_a_i / req_b_i / req_c_i  in  32 each  operands a, b, c
- req_vmode_i  in  2  vector mode
- req_tag_i  in  4  tag returned with the response
- alu_enable_o  out  1  to ALU `enable_i`
- alu_operator_o  out  alu_opcode_e  to `operator_i`
- alu_a_o / alu_b_o / alu_c_o  out  32 each  to `operand_a/b/c_i`
- alu_vmode_o  out  2  to `vector_mode_i`
- alu_bmask_a_o / alu_bmask_b_o  out  5 each  constant 0
- alu_imm_vec_ext_o  out  2  constant 0
- alu_is_clpx_o / alu_is_subrot_o  out  1 each  constant 0
- alu_clpx_shift_o  out  2  constant 0
- alu_ready_i  in  1  ALU `ready_o`
- alu_result_i  in  32  ALU `result_o`
- alu_cmp_i  in  1  ALU `comparison_result_o`
- alu_ex_ready_o  out  1  to ALU `ex_ready_i`
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid & ready
- rsp_result_o  out  32  captured result
- rsp_cmp_o  out  1  captured comparison bit
- rsp_tag_o  out  4  tag of the request
- rsp_timeout_o  out  1  1 = operation aborted by timeout

## Operation
Request FIFO:
- DEPTH entries; `req_ready_o = !full`. It is combinational from the count and does not depend on a same-cycle pop.
- Push and pop in the same cycle are both performed; the count is unchanged.
- Pointers wrap modulo DEPTH.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: go to ISSUE when the FIFO is non-empty. Pop the head into the issue register on the transition.
- ISSUE:
  - Drive `alu_enable_o=1` with issue-register fields.
  - If `alu_ready_i=1`: assert `alu_ex_ready_o`, capture result and cmp, go to RESP.
  - Otherwise clear the wait counter and go to WAIT.
- WAIT:
  - Keep `alu_enable_o=1`; fields stay unchanged.
  - Counter increments each cycle.
  - On `alu_ready_i=1`: assert `alu_ex_ready_o`, capture, go to RESP.
  - When the counter reaches TIMEOUT-1 without ready: capture result=0 and cmp=0, set the timeout flag, go to RESP.
  - Ready and the limit in the same cycle: ready wins and timeout=0.
- RESP:
  - `rsp_valid_o=1`; response fields held until `rsp_ready_i`.
  - On handshake: if the FIFO is non-empty, pop and go to ISSUE directly (back-to-back); else go to IDLE.
- `alu_enable_o=0` and `alu_ex_ready_o=0` in IDLE and RESP.
- ALU-side data outputs keep the issue-register value and change only on a pop.
- Operands pass through unmodified: no width conversion, no sign handling.

## Timing
- Reset (`rst_n=0` at an edge):
  - FIFO emptied, FSM to IDLE, issue register and response register cleared.
  - All outputs 0, except `req_ready_o=1` in the cycle after reset is released.
- Reset mid-operation drops the in-flight op; no response is produced for it.
- Single-cycle op latency:
  - Request accepted at edge N.
  - ISSUE during cycle N+1 with result captured at its end.
  - `rsp_valid_o` during cycle N+2.
- Multi-cycle op: `rsp_valid_o` one cycle after the cycle `alu_ready_i` is sampled high.
- `alu_ex_ready_o` is a 1-cycle pulse, coincident with the capture cycle only.
- Throughput with `rsp_ready_i` held at 1: one single-cycle op per 2 cycles (ISSUE, RESP).
- Timeout: RESP entered exactly TIMEOUT cycles after ISSUE, counting ISSUE as cycle 0.

## Test plan
- Reset, then ADD a=5 b=7 tag=3 with ALU ready=1 → `alu_enable_o` high 1 cycle; rsp_result=12, tag=3, timeout=0, two cycles after acceptance.
- DIV a=100 b=7 with `alu_ready_i` low for 34 cycles → operator and operands stable for all WAIT cycles; single `alu_ex_ready_o` pulse; result=14.
- Push 5 requests with DEPTH=4 and `rsp_ready_i=0` → `req_ready_o` drops after the 4th FIFO entry; responses return later in order, tags 0..4, none lost.
- `alu_ready_i` held 0, TIMEOUT=64 → RESP 64 cycles after ISSUE; result=0, timeout=1; next request then issues normally.
- `rst_n` low during WAIT → next cycle all outputs 0 and FIFO empty; no response for the dropped op.
- `rsp_ready_i` toggling randomly over 8 back-to-back SLT/SLTU compares → `rsp_cmp_o`/result match the reference model; fields stable while valid & !ready.
